// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between requester A (pipeline execute path) and
// requester B (auxiliary unit). Round-robin arbitration. Each operation runs
// IDLE (accept) -> EXEC (ALU sees registered operands) -> RESP (result held
// until the granted requester takes it).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation in flight; the round-robin winner sees req_ready
// EXEC  | registered operands drive the ALU for one cycle
// RESP  | result held; granted rsp_valid high until its rsp_ready
module alu_share_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CTRL_W   = 4,
  parameter int MAX_CTRL = 11
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [WIDTH-1:0]  a_num1,
  input  logic [WIDTH-1:0]  a_num2,
  input  logic [CTRL_W-1:0] a_ctrl,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,

  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [WIDTH-1:0]  b_num1,
  input  logic [WIDTH-1:0]  b_num2,
  input  logic [CTRL_W-1:0] b_ctrl,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,

  output logic [WIDTH-1:0]  rsp_rlt,
  output logic              rsp_zero,
  output logic              rsp_err,

  output logic [WIDTH-1:0]  alu_num1,
  output logic [WIDTH-1:0]  alu_num2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_rlt,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_e              state_q;
  logic                last_grant_q;
  logic                gnt_q;
  logic                err_q;
  logic [WIDTH-1:0]    alu_num1_q;
  logic [WIDTH-1:0]    alu_num2_q;
  logic [CTRL_W-1:0]   alu_ctrl_q;
  logic [WIDTH-1:0]    rsp_rlt_q;
  logic                rsp_zero_q;
  logic                rsp_err_q;
  logic                a_rsp_valid_q;
  logic                b_rsp_valid_q;

  logic                win_b;
  logic                accept;
  logic [WIDTH-1:0]    sel_num1;
  logic [WIDTH-1:0]    sel_num2;
  logic [CTRL_W-1:0]   sel_ctrl;
  logic                sel_illegal;
  logic                rsp_hs;

  // Round-robin winner and request-side handshake, decoded from state and valids.
  always_comb begin
    win_b       = b_req_valid && (!a_req_valid || (last_grant_q == GNT_A));
    accept      = (state_q == ST_IDLE) && (a_req_valid || b_req_valid);
    a_req_ready = (state_q == ST_IDLE) && a_req_valid && !win_b;
    b_req_ready = (state_q == ST_IDLE) && win_b;
    sel_num1    = win_b ? b_num1 : a_num1;
    sel_num2    = win_b ? b_num2 : a_num2;
    sel_ctrl    = win_b ? b_ctrl : a_ctrl;
    sel_illegal = (sel_ctrl > CTRL_W'(MAX_CTRL));
    rsp_hs      = (gnt_q == GNT_A) ? a_rsp_ready : b_rsp_ready;
  end

  // Sequencer: accept, one EXEC cycle to capture the ALU, then hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GNT_B;
      gnt_q         <= GNT_A;
      err_q         <= 1'b0;
      alu_num1_q    <= '0;
      alu_num2_q    <= '0;
      alu_ctrl_q    <= '0;
      rsp_rlt_q     <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            alu_num1_q   <= sel_num1;
            alu_num2_q   <= sel_num2;
            // Illegal codes never reach the ALU; it sees a defined code instead.
            alu_ctrl_q   <= sel_illegal ? '0 : sel_ctrl;
            err_q        <= sel_illegal;
            gnt_q        <= win_b;
            last_grant_q <= win_b;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_rlt_q     <= err_q ? '0 : alu_rlt;
          rsp_zero_q    <= err_q ? 1'b0 : alu_zero;
          rsp_err_q     <= err_q;
          a_rsp_valid_q <= (gnt_q == GNT_A);
          b_rsp_valid_q <= (gnt_q == GNT_B);
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          a_rsp_valid_q <= 1'b0;
          b_rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_num1    = alu_num1_q;
  assign alu_num2    = alu_num2_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign rsp_rlt     = rsp_rlt_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU stands in for the shared ALU,
// and a transaction-level model predicts the winner and the returned response.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [31:0] a_num1, a_num2;
  logic [3:0]  a_ctrl;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [31:0] b_num1, b_num2;
  logic [3:0]  b_ctrl;
  logic [31:0] rsp_rlt;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_num1, alu_num2, alu_rlt;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;

  // Requests waiting to be driven (a pending request keeps its operands).
  logic        av, bv;
  logic [31:0] an1, an2, bn1, bn2;
  logic [3:0]  ac, bc;
  int          stall;

  // Model state: who was granted last (0 = A, 1 = B) and what the ALU last saw.
  int          model_last;
  logic [3:0]  model_alu_ctrl;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4), .MAX_CTRL(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_num1(a_num1), .a_num2(a_num2), .a_ctrl(a_ctrl),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_num1(b_num1), .b_num2(b_num2), .b_ctrl(b_ctrl),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .rsp_rlt(rsp_rlt), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_ctrl(alu_ctrl),
    .alu_rlt(alu_rlt), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'd0:    return x & y;
      4'd1:    return x + y;
      4'd2:    return x - y;
      4'd3:    return x ^ y;
      4'd4:    return x | y;
      4'd5:    return x << y[4:0];
      4'd6:    return x >> y[4:0];
      4'd7:    return 32'($signed(x) >>> y[4:0]);
      4'd8:    return {31'b0, ($signed(x) < $signed(y))};
      4'd9:    return {31'b0, (x < y)};
      4'd10:   return y;
      4'd11:   return ~(x | y);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_rlt  = alu_fn(alu_ctrl, alu_num1, alu_num2);
  assign alu_zero = (alu_num1 == alu_num2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
    a_num1 = 0; a_num2 = 0; a_ctrl = 0; b_num1 = 0; b_num2 = 0; b_ctrl = 0;
    av = 0; bv = 0;
    #12;
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_num1", alu_num1, 0);
    chk("rst_rsp_rlt", rsp_rlt, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_last = 1;
    model_alu_ctrl = 4'd0;
  endtask

  // One arbitration round from IDLE: check grant, EXEC operands and the held response.
  task automatic run_op();
    logic        wb, ee, ez;
    logic [31:0] n1, n2, er;
    logic [3:0]  c, ec;
    a_req_valid = av; a_num1 = an1; a_num2 = an2; a_ctrl = ac;
    b_req_valid = bv; b_num1 = bn1; b_num2 = bn2; b_ctrl = bc;
    #2;
    if (!av && !bv) begin
      chk("idle_a_ready", a_req_ready, 0);
      chk("idle_b_ready", b_req_ready, 0);
      @(posedge clk); #1;
      chk("idle_hold_ctrl", alu_ctrl, model_alu_ctrl);
      chk("idle_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
      return;
    end
    if (av && bv) wb = (model_last == 0);
    else          wb = bv;
    n1 = wb ? bn1 : an1;
    n2 = wb ? bn2 : an2;
    c  = wb ? bc  : ac;
    ee = (c > 4'd11);
    ec = ee ? 4'd0 : c;
    er = ee ? 32'd0 : alu_fn(c, n1, n2);
    ez = ee ? 1'b0 : (n1 == n2);
    chk("acc_a_ready", a_req_ready, !wb);
    chk("acc_b_ready", b_req_ready, wb);
    @(posedge clk); #1;
    if (wb) begin bv = 0; b_req_valid = 0; end
    else    begin av = 0; a_req_valid = 0; end
    model_last = wb ? 1 : 0;
    model_alu_ctrl = ec;
    chk("exec_num1", alu_num1, n1);
    chk("exec_num2", alu_num2, n2);
    chk("exec_ctrl", alu_ctrl, ec);
    chk("exec_readies", {a_req_ready, b_req_ready}, 0);
    chk("exec_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    @(posedge clk); #1;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) begin
        a_rsp_ready = !wb; b_rsp_ready = wb;
      end else begin
        a_rsp_ready = wb;  b_rsp_ready = !wb;
      end
      #1;
      chk("resp_a_valid", a_rsp_valid, !wb);
      chk("resp_b_valid", b_rsp_valid, wb);
      chk("resp_rlt", rsp_rlt, er);
      chk("resp_zero", rsp_zero, ez);
      chk("resp_err", rsp_err, ee);
      chk("resp_readies", {a_req_ready, b_req_ready}, 0);
      @(posedge clk); #1;
    end
    a_rsp_ready = 0; b_rsp_ready = 0;
    chk("post_hs_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stall = 0; an1 = 0; an2 = 0; ac = 0; bn1 = 0; bn2 = 0; bc = 0;
    do_reset();

    // Single ADD from A.
    av = 1; an1 = 5; an2 = 7; ac = 4'b0001;
    run_op();

    // Simultaneous SUB (A) and OR (B) from a fresh reset: A first, then B.
    do_reset();
    av = 1; an1 = 10; an2 = 3; ac = 4'b0010;
    bv = 1; bn1 = 32'hF0; bn2 = 32'h0F; bc = 4'b0100;
    run_op();
    run_op();

    // Both held valid for four operations: grants alternate A, B, A, B.
    for (int k = 0; k < 4; k++) begin
      av = 1; an1 = 32'(k + 100); an2 = 32'(k); ac = 4'd1;
      bv = 1; bn1 = 32'(k + 200); bn2 = 32'(k); bc = 4'd2;
      run_op();
      av = 0; bv = 0;
    end

    // Zero flag: B SUB equal operands, then A SLTU 3<9.
    bv = 1; bn1 = 32'h1234; bn2 = 32'h1234; bc = 4'b0010;
    run_op();
    av = 1; an1 = 3; an2 = 9; ac = 4'b1001;
    run_op();

    // Illegal control code.
    av = 1; an1 = 1; an2 = 1; ac = 4'b1111;
    run_op();

    // Backpressure on A's response while B waits; B then accepted next cycle.
    do_reset();
    av = 1; an1 = 32'h55; an2 = 32'h0F; ac = 4'd3;
    bv = 1; bn1 = 32'h8; bn2 = 32'h2; bc = 4'd5;
    stall = 5;
    run_op();
    stall = 0;
    run_op();

    // Reset during EXEC drops the operation.
    av = 1; an1 = 32'h77; an2 = 32'h11; ac = 4'd1;
    a_req_valid = 1; a_num1 = an1; a_num2 = an2; a_ctrl = ac;
    @(posedge clk); #1;
    a_req_valid = 0; av = 0;
    chk("rexec_ctrl_before", alu_ctrl, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rexec_num1", alu_num1, 0);
    chk("rexec_ctrl", alu_ctrl, 0);
    chk("rexec_rsp", {rsp_rlt[0], rsp_zero, rsp_err, a_rsp_valid, b_rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    model_alu_ctrl = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rexec_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    end
    av = 1; an1 = 32'h9; an2 = 32'h9; ac = 4'd0;
    bv = 1; bn1 = 32'h3; bn2 = 32'h4; bc = 4'd8;
    run_op();
    run_op();

    // Randomized traffic with random response stalls.
    for (int it = 0; it < 60; it++) begin
      if (!av && ($urandom_range(2) != 0)) begin
        av = 1; an1 = $urandom; an2 = ($urandom_range(3) == 0) ? an1 : $urandom;
        ac = 4'($urandom_range(15));
      end
      if (!bv && ($urandom_range(2) != 0)) begin
        bv = 1; bn1 = $urandom; bn2 = ($urandom_range(3) == 0) ? bn1 : $urandom;
        bc = 4'($urandom_range(15));
      end
      stall = $urandom_range(3);
      run_op();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
